// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - one-access-per-clkref-slot arbiter for boot/CPU/DMA onto the SDRAM CPU port.
// Optional ARB_STATS_EN adds saturating per-requester grant counters with a synchronous clear.
module sdram_port_arbiter #(
  parameter int SLOT_LAT   = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic        boot_req,
  input  logic [22:0] boot_addr,
  input  logic        boot_bank,
  input  logic [7:0]  boot_din,
  output logic        boot_ack,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic        cpu_bank,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [22:0] dma_addr,
  input  logic        dma_bank,
  input  logic [7:0]  dma_din,
  output logic [7:0]  dma_dout,
  output logic        dma_ack,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [22:0] sd_addr,
  output logic        sd_bank,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  output logic [1:0]  owner
`ifdef ARB_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_boot,
  output logic [15:0] stat_cpu,
  output logic [15:0] stat_dma
`endif
);

  localparam int CW = $clog2(SLOT_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [1:0] OWN_NONE = 2'd0, OWN_BOOT = 2'd1, OWN_CPU = 2'd2, OWN_DMA = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [1:0]  owner_q, owner_d;
  logic        we_q, we_d;
  logic [22:0] addr_q, addr_d;
  logic        bank_q, bank_d;
  logic [7:0]  din_q, din_d;
  logic        boot_ack_q, boot_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic [7:0]  dma_dout_q, dma_dout_d;
  logic        any_req, dma_first, grant;

  assign any_req   = boot_req | cpu_rd | cpu_wr | dma_req;
  assign dma_first = dma_req && (starve_q == SW'(STARVE_MAX));
  assign grant     = (state_q == S_IDLE) && clkref && any_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    din_d      = din_q;
    boot_ack_d = 1'b0;
    cpu_ack_d  = 1'b0;
    dma_ack_d  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    dma_dout_d = dma_dout_q;
    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d = S_ACCESS;
          cnt_d   = '0;
          if (boot_req) begin
            owner_d = OWN_BOOT;
            we_d    = 1'b1;
            addr_d  = boot_addr;
            bank_d  = boot_bank;
            din_d   = boot_din;
          end else if ((cpu_rd || cpu_wr) && !dma_first) begin
            owner_d = OWN_CPU;
            we_d    = cpu_wr;
            addr_d  = cpu_addr;
            bank_d  = cpu_bank;
            din_d   = cpu_din;
          end else begin
            owner_d = OWN_DMA;
            we_d    = dma_we;
            addr_d  = dma_addr;
            bank_d  = dma_bank;
            din_d   = dma_din;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == CW'(SLOT_LAT - 1)) state_d = S_DONE;
        else cnt_d = cnt_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
        case (owner_q)
          OWN_BOOT: boot_ack_d = 1'b1;
          OWN_CPU: begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_dout_d = sd_dout;
          end
          OWN_DMA: begin
            dma_ack_d = 1'b1;
            if (!we_q) dma_dout_d = sd_dout;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    // Starvation is measured against the CPU only; boot slots leave the count alone.
    if (!dma_req) starve_d = '0;
    else if (grant && owner_d == OWN_DMA) starve_d = '0;
    else if (grant && owner_d == OWN_CPU && starve_q != SW'(STARVE_MAX)) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      owner_q    <= OWN_NONE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      bank_q     <= 1'b0;
      din_q      <= '0;
      boot_ack_q <= 1'b0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      cpu_dout_q <= '0;
      dma_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      din_q      <= din_d;
      boot_ack_q <= boot_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      dma_ack_q  <= dma_ack_d;
      cpu_dout_q <= cpu_dout_d;
      dma_dout_q <= dma_dout_d;
    end
  end

  // Strobes derive from state so an async reset drops them immediately.
  assign sd_oe    = (state_q == S_ACCESS) && !we_q;
  assign sd_we    = (state_q == S_ACCESS) && we_q;
  assign sd_addr  = addr_q;
  assign sd_bank  = bank_q;
  assign sd_din   = din_q;
  assign owner    = owner_q;
  assign boot_ack = boot_ack_q;
  assign cpu_ack  = cpu_ack_q;
  assign dma_ack  = dma_ack_q;
  assign cpu_dout = cpu_dout_q;
  assign dma_dout = dma_dout_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_boot_q, stat_boot_d;
  logic [15:0] stat_cpu_q, stat_cpu_d;
  logic [15:0] stat_dma_q, stat_dma_d;

  always_comb begin
    stat_boot_d = stat_boot_q;
    stat_cpu_d  = stat_cpu_q;
    stat_dma_d  = stat_dma_q;
    if (stat_clr) begin
      stat_boot_d = '0;
      stat_cpu_d  = '0;
      stat_dma_d  = '0;
    end else if (grant) begin
      if (owner_d == OWN_BOOT && stat_boot_q != 16'hFFFF) stat_boot_d = stat_boot_q + 16'd1;
      if (owner_d == OWN_CPU  && stat_cpu_q  != 16'hFFFF) stat_cpu_d  = stat_cpu_q + 16'd1;
      if (owner_d == OWN_DMA  && stat_dma_q  != 16'hFFFF) stat_dma_d  = stat_dma_q + 16'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      stat_boot_q <= '0;
      stat_cpu_q  <= '0;
      stat_dma_q  <= '0;
    end else begin
      stat_boot_q <= stat_boot_d;
      stat_cpu_q  <= stat_cpu_d;
      stat_dma_q  <= stat_dma_d;
    end
  end

  assign stat_boot = stat_boot_q;
  assign stat_cpu  = stat_cpu_q;
  assign stat_dma  = stat_dma_q;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter.
module tb_sdram_port_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset_n, clkref;
  logic        boot_req, boot_bank, boot_ack;
  logic [22:0] boot_addr, cpu_addr, dma_addr, sd_addr;
  logic [7:0]  boot_din, cpu_din, cpu_dout, dma_din, dma_dout, sd_din, sd_dout;
  logic        cpu_rd, cpu_wr, cpu_bank, cpu_ack;
  logic        dma_req, dma_we, dma_bank, dma_ack;
  logic        sd_oe, sd_we, sd_bank;
  logic [1:0]  owner;
`ifdef ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_boot, stat_cpu, stat_dma;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .clkref(clkref),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_bank(boot_bank), .boot_din(boot_din), .boot_ack(boot_ack),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_bank(cpu_bank), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_bank(dma_bank), .dma_din(dma_din),
    .dma_dout(dma_dout), .dma_ack(dma_ack),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_bank(sd_bank), .sd_din(sd_din), .sd_dout(sd_dout),
    .owner(owner)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_boot(stat_boot), .stat_cpu(stat_cpu), .stat_dma(stat_dma)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: pulses clkref, then measures the slot until any ack (bounded).
  task automatic run_slot(output logic [1:0] own, output int lat, output int oe_n,
                          output int we_n, output logic [7:0] din_g);
    clkref = 1'b1;
    @(negedge clk_sys);
    clkref = 1'b0;
    own = owner; din_g = sd_din; lat = 0; oe_n = 0; we_n = 0;
    while (!(boot_ack || cpu_ack || dma_ack) && lat < 30) begin
      if (sd_oe) oe_n++;
      if (sd_we) we_n++;
      @(negedge clk_sys);
      lat++;
    end
  endtask

  logic [1:0] own;
  logic [7:0] din_g;
  int lat, oe_n, we_n, acks;
  logic [1:0] exp_own [7];

  initial begin
    exp_own = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd2};
    reset_n = 1'b0; clkref = 1'b1;
    boot_req = 1'b1; cpu_rd = 1'b1; cpu_wr = 1'b1; dma_req = 1'b1; dma_we = 1'b0;
    boot_addr = 23'h000010; boot_bank = 1'b0; boot_din = 8'h11;
    cpu_addr = 23'h000200; cpu_bank = 1'b1; cpu_din = 8'h22;
    dma_addr = 23'h000300; dma_bank = 1'b0; dma_din = 8'h33;
    sd_dout = 8'hA5;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_sys);
    chk("rst_owner", {30'd0, owner}, 32'd0);
    chk("rst_strobes", {29'd0, sd_oe, sd_we, sd_bank}, 32'd0);
    chk("rst_acks", {29'd0, boot_ack, cpu_ack, dma_ack}, 32'd0);
    chk("rst_addr", {9'd0, sd_addr}, 32'd0);
    chk("rst_douts", {16'd0, cpu_dout, dma_dout}, 32'd0);
    clkref = 1'b0; reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Contention: boot first, then CPU four times, then starved DMA, then CPU again.
    for (int s = 0; s < 7; s++) begin
      run_slot(own, lat, oe_n, we_n, din_g);
      chk($sformatf("cont_owner%0d", s), {30'd0, own}, {30'd0, exp_own[s]});
      chk($sformatf("cont_lat%0d", s), lat, 32'd9);
      if (s == 0) begin
        chk("boot_din", {24'd0, din_g}, 32'h11);
        chk("boot_we", we_n, 32'd8);
        boot_req = 1'b0;
      end
      if (s == 1) begin
        chk("rdwr_we", we_n, 32'd8);
        chk("rdwr_oe", oe_n, 32'd0);
        chk("rdwr_din", {24'd0, din_g}, 32'h22);
      end
      if (s == 5) begin
        chk("dma_oe", oe_n, 32'd8);
        chk("dma_dout", {24'd0, dma_dout}, 32'hA5);
        dma_req = 1'b0;
      end
    end
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    @(negedge clk_sys);
    chk("cont_ack_pulse", {31'd0, cpu_ack}, 32'd0);

    // CPU read; request waits for clkref, address change and mid-slot clkref are ignored.
    sd_dout = 8'h5A; cpu_addr = 23'h000123; cpu_rd = 1'b1;
    repeat (3) @(negedge clk_sys);
    chk("wait_clkref", {30'd0, owner}, 32'd0);
    fork
      run_slot(own, lat, oe_n, we_n, din_g);
      begin
        repeat (2) @(negedge clk_sys);
        cpu_addr = 23'h7FFFFF;
        clkref = 1'b1;
        @(negedge clk_sys);
        clkref = 1'b0;
      end
    join
    chk("rd_owner", {30'd0, own}, 32'd2);
    chk("rd_lat", lat, 32'd9);
    chk("rd_oe", oe_n, 32'd8);
    chk("rd_we", we_n, 32'd0);
    chk("rd_dout", {24'd0, cpu_dout}, 32'h5A);
    chk("rd_addr_held", {9'd0, sd_addr}, 32'h000123);
    cpu_rd = 1'b0;
    @(negedge clk_sys);
    chk("rd_ack_pulse", {31'd0, cpu_ack}, 32'd0);
    chk("rd_dout_hold", {24'd0, cpu_dout}, 32'h5A);

    // Abort: reset at cycle 3 of a CPU write slot.
    cpu_wr = 1'b1;
    clkref = 1'b1;
    @(negedge clk_sys);
    clkref = 1'b0;
    chk("ab_we_before", {31'd0, sd_we}, 32'd1);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b0;
    #1;
    chk("ab_we_now", {31'd0, sd_we}, 32'd0);
    chk("ab_owner", {30'd0, owner}, 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1; cpu_wr = 1'b0;
    acks = 0;
    repeat (12) begin
      @(negedge clk_sys);
      if (boot_ack || cpu_ack || dma_ack || owner != 2'd0) acks++;
    end
    chk("ab_no_ack", acks, 32'd0);
    dma_req = 1'b1; dma_we = 1'b1; dma_din = 8'h77;
    run_slot(own, lat, oe_n, we_n, din_g);
    chk("ab_dma_owner", {30'd0, own}, 32'd3);
    chk("ab_dma_lat", lat, 32'd9);
    chk("ab_dma_din", {24'd0, din_g}, 32'h77);
    dma_req = 1'b0;
    @(negedge clk_sys);

`ifdef ARB_STATS_EN
    stat_clr = 1'b1;
    @(negedge clk_sys);
    stat_clr = 1'b0;
    cpu_rd = 1'b1;
    repeat (10) begin
      run_slot(own, lat, oe_n, we_n, din_g);
    end
    cpu_rd = 1'b0; dma_req = 1'b1; dma_we = 1'b0;
    repeat (3) begin
      run_slot(own, lat, oe_n, we_n, din_g);
    end
    dma_req = 1'b0;
    @(negedge clk_sys);
    chk("stat_cpu", {16'd0, stat_cpu}, 32'd10);
    chk("stat_dma", {16'd0, stat_dma}, 32'd3);
    chk("stat_boot", {16'd0, stat_boot}, 32'd0);
    stat_clr = 1'b1;
    @(negedge clk_sys);
    stat_clr = 1'b0;
    chk("stat_clr", {16'd0, stat_cpu | stat_dma | stat_boot}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
